vga_sram_pixel_writer: RTL and testbench
========================================

// Module: vga_sram_pixel_writer
// PURPOSE
//  Write side of the packed-RGB SRAM frame buffer that the VGA display path reads.
//  Accepts a stream of 24-bit RGB pixels over a valid/ready handshake.
//  Packs each pixel pair into three 16-bit words: {R0,G0}, {B0,R1}, {G1,B1}.
//  Writes the words to consecutive SRAM addresses from a base address.
//  Sits between a pixel source (UART/image loader, pattern generator) and the SRAM controller.
// PARAMETERS
//  NUM_PIXELS   76800   pixels per frame (320x240); must be even and nonzero; elaboration error otherwise
// PORTS
//  Clock              in   1   system clock, all logic on posedge
//  Reset              in   1   asynchronous, active-high reset
//  Start              in   1   one-cycle pulse: begin a frame; ignored while Busy
//  SRAM_base_address  in   18  first word address; sampled when Start is accepted
//  Pixel_valid        in   1   source has a pixel on Pixel_R/G/B
//  Pixel_ready        out  1   block accepts a pixel this cycle (transfer = valid & ready)
//  Pixel_R/G/B        in   8   pixel colour components (three ports)
//  SRAM_address       out  18  write address
//  SRAM_write_data    out  16  write data
//  SRAM_we_n          out  1   active-low write enable; one word per low cycle
//  Busy               out  1   high from the cycle after Start is accepted until Done
//  Done               out  1   one-cycle pulse after the last word of the frame is written
// BEHAVIOUR
//  Reset values: SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, Pixel_ready=0, Busy=0, Done=0.
//   Reset takes effect immediately, including mid-frame; the partial frame is abandoned.
//  All outputs are registered; SRAM_address, SRAM_write_data and SRAM_we_n change together.
//  States (PW_state_type):
//   S_PW_IDLE: ready=0. On Start: word pointer<=base, pixel count<=0, Busy<=1, go S_PW_PIX0.
//   S_PW_PIX0: ready=1. On transfer: next cycle we_n=0, addr=ptr, data={R,G}. Buffer B. Go S_PW_PIX1.
//   S_PW_PIX1: ready=1. On transfer: next cycle we_n=0, addr=ptr, data={B0,R}. Buffer G,B. Go S_PW_WORD2.
//   S_PW_WORD2: ready=0. Next cycle we_n=0, addr=ptr, data={G1,B1}.
//     Then, if pixel count==NUM_PIXELS: Done<=1, Busy<=0, go S_PW_IDLE. Otherwise go S_PW_PIX0.
//  Every write post-increments the word pointer by 1; addresses are contiguous.
//   Wrap at 2^18 is modulo 18 bits with no error.
//  Stall: with valid=0 in PIX0/PIX1, no write occurs (we_n=1) and the pointer and buffers hold.
//  Throughput: 2 pixels per 3 cycles when valid is held high.
//   Pixel_ready is low exactly in WORD2 and IDLE.
//  Start in any state other than IDLE: ignored, no effect.
//  Start coincident with Done cycle: ignored. Start is accepted only in IDLE.
//  Pixel count is 17 bits (covers 76800); increments on each transfer.
//  Frame size in words is 3*NUM_PIXELS/2.
//  Data packing matches the display reader exactly.
//   Even pixel: R in word0[15:8], G in word0[7:0], B in word1[15:8].
//   Odd pixel: R in word1[7:0], G in word2[15:8], B in word2[7:0].
// STRUCTURE
//  Add typedef enum PW_state_type {S_PW_IDLE,S_PW_PIX0,S_PW_PIX1,S_PW_WORD2} to define_state.h.
//  Add the default frame constants (320x240) to the same shared header.
//  No sub-module: a single FSM with a pointer register, a pixel counter and a 16-bit colour buffer.
// TESTING
//  1 Assert Reset mid-frame -> we_n=1, ready=0, Busy=0 at once; a new Start after release begins at base.
//  2 NUM_PIXELS=2, base 0, pixels (11,22,33),(44,55,66) back-to-back
//     -> writes 0:1122, 1:3344, 2:5566 on 3 consecutive cycles; Done 1 cycle later.
//  3 Same pixels with valid low for 4 cycles between them
//     -> no writes during gap; addresses still 0,1,2; data identical.
//  4 NUM_PIXELS=4, base 0x3FFFE, ramp pixels
//     -> 6 writes at 3FFFE,3FFFF,0,1,2,3; exactly one Done pulse; ready=0 afterwards.
//  5 Start pulsed during frame -> ignored; word count and addresses unchanged.
//     Start in IDLE after Done -> new frame from newly sampled base.
//  6 Full 320x240 frame, then read back via the display path model
//     -> 115200 words written; displayed RGB equals source for every pixel.

Source files
------------

// File: rtl/vga_sram_pixel_writer_pkg.sv
// Shared definitions for the packed-RGB frame buffer writer.
//   PW_state_type     : writer FSM states
//   FRAME_*           : default frame geometry (320x240)
//   SRAM_*_W          : SRAM word address / data widths
//   PIX_CNT_W         : width of the per-frame pixel counter
package vga_sram_pixel_writer_pkg;

  localparam int unsigned FRAME_WIDTH  = 320;
  localparam int unsigned FRAME_HEIGHT = 240;
  localparam int unsigned FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned PIX_CNT_W   = 17;

  typedef enum logic [1:0] {
    S_PW_IDLE,
    S_PW_PIX0,
    S_PW_PIX1,
    S_PW_WORD2
  } PW_state_type;

endpackage

// File: rtl/vga_sram_pixel_writer.sv
// Write side of the packed-RGB SRAM frame buffer.
// Accepts 24-bit pixels over valid/ready, packs each pixel pair into three
// 16-bit words {R0,G0},{B0,R1},{G1,B1} and writes them to consecutive
// addresses starting at the base sampled on an accepted Start.
// Ports:
//   Clock, Reset          : system clock, async active-high reset
//   Start                 : one-cycle frame start pulse (accepted only when idle)
//   SRAM_base_address     : first word address of the frame
//   Pixel_valid/_ready    : pixel handshake; Pixel_R/G/B carry the colour
//   SRAM_address/_write_data/_we_n : registered SRAM write port
//   Busy                  : frame in progress
//   Done                  : one-cycle pulse after the last word is written
module vga_sram_pixel_writer
  import vga_sram_pixel_writer_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = FRAME_PIXELS
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic [SRAM_ADDR_W-1:0] SRAM_base_address,
  input  logic                   Pixel_valid,
  output logic                   Pixel_ready,
  input  logic [7:0]             Pixel_R,
  input  logic [7:0]             Pixel_G,
  input  logic [7:0]             Pixel_B,
  output logic [SRAM_ADDR_W-1:0] SRAM_address,
  output logic [SRAM_DATA_W-1:0] SRAM_write_data,
  output logic                   SRAM_we_n,
  output logic                   Busy,
  output logic                   Done
);

  if (NUM_PIXELS == 0 || (NUM_PIXELS % 2) != 0 || NUM_PIXELS >= (1 << PIX_CNT_W)) begin : g_bad_num_pixels
    $error("NUM_PIXELS must be even, nonzero and fit the pixel counter");
  end

  PW_state_type           state, state_n;
  logic [SRAM_ADDR_W-1:0] word_ptr, word_ptr_n;
  logic [PIX_CNT_W-1:0]   pix_cnt, pix_cnt_n;
  logic [15:0]            colour_buf, colour_buf_n;
  logic                   done_pending, done_pending_n;

  logic                   ready_n, we_n_n, busy_n, done_n;
  logic [SRAM_ADDR_W-1:0] addr_n;
  logic [SRAM_DATA_W-1:0] data_n;
  logic                   xfer;

  assign xfer = Pixel_valid & Pixel_ready;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state           <= S_PW_IDLE;
      word_ptr        <= '0;
      pix_cnt         <= '0;
      colour_buf      <= '0;
      done_pending    <= 1'b0;
      Pixel_ready     <= 1'b0;
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
      Busy            <= 1'b0;
      Done            <= 1'b0;
    end else begin
      state           <= state_n;
      word_ptr        <= word_ptr_n;
      pix_cnt         <= pix_cnt_n;
      colour_buf      <= colour_buf_n;
      done_pending    <= done_pending_n;
      Pixel_ready     <= ready_n;
      SRAM_address    <= addr_n;
      SRAM_write_data <= data_n;
      SRAM_we_n       <= we_n_n;
      Busy            <= busy_n;
      Done            <= done_n;
    end
  end

  always_comb begin
    state_n        = state;
    word_ptr_n     = word_ptr;
    pix_cnt_n      = pix_cnt;
    colour_buf_n   = colour_buf;
    done_pending_n = 1'b0;
    addr_n         = SRAM_address;
    data_n         = SRAM_write_data;
    we_n_n         = 1'b1;
    busy_n         = Busy;
    done_n         = 1'b0;

    unique case (state)
      S_PW_IDLE: begin
        // The last word leaves WORD2 together with done_pending, so Done
        // lands one cycle after that write; Start is refused in that cycle
        // (Busy still high) and in the Done cycle itself.
        if (done_pending) begin
          done_n = 1'b1;
          busy_n = 1'b0;
        end else if (Start && !Busy && !Done) begin
          word_ptr_n = SRAM_base_address;
          pix_cnt_n  = '0;
          busy_n     = 1'b1;
          state_n    = S_PW_PIX0;
        end
      end
      S_PW_PIX0: begin
        if (xfer) begin
          we_n_n            = 1'b0;
          addr_n            = word_ptr;
          data_n            = {Pixel_R, Pixel_G};
          word_ptr_n        = word_ptr + 1'b1;
          pix_cnt_n         = pix_cnt + 1'b1;
          colour_buf_n[7:0] = Pixel_B;
          state_n           = S_PW_PIX1;
        end
      end
      S_PW_PIX1: begin
        if (xfer) begin
          we_n_n       = 1'b0;
          addr_n       = word_ptr;
          data_n       = {colour_buf[7:0], Pixel_R};
          word_ptr_n   = word_ptr + 1'b1;
          pix_cnt_n    = pix_cnt + 1'b1;
          colour_buf_n = {Pixel_G, Pixel_B};
          state_n      = S_PW_WORD2;
        end
      end
      S_PW_WORD2: begin
        we_n_n     = 1'b0;
        addr_n     = word_ptr;
        data_n     = colour_buf;
        word_ptr_n = word_ptr + 1'b1;
        if (pix_cnt == PIX_CNT_W'(NUM_PIXELS)) begin
          done_pending_n = 1'b1;
          state_n        = S_PW_IDLE;
        end else begin
          state_n = S_PW_PIX0;
        end
      end
      default: state_n = S_PW_IDLE;
    endcase

    // Registered ready tracks the state being entered.
    ready_n = (state_n == S_PW_PIX0) || (state_n == S_PW_PIX1);
  end

endmodule

// File: tb/tb_vga_sram_pixel_writer.sv
module tb_vga_sram_pixel_writer;
  localparam int NP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [17:0] base;
  logic        valid;
  logic        ready;
  logic [7:0]  pr, pg, pb;
  logic [17:0] addr;
  logic [15:0] wdata;
  logic        we_n, busy, done;

  always #5 clk = ~clk;

  vga_sram_pixel_writer #(.NUM_PIXELS(NP)) dut (
    .Clock(clk), .Reset(rst), .Start(start), .SRAM_base_address(base),
    .Pixel_valid(valid), .Pixel_ready(ready),
    .Pixel_R(pr), .Pixel_G(pg), .Pixel_B(pb),
    .SRAM_address(addr), .SRAM_write_data(wdata), .SRAM_we_n(we_n),
    .Busy(busy), .Done(done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Behavioural model: tracks pixels accepted, pair parity and pending
  // third word; predicts the registered outputs after every edge.
  logic        m_ready, m_busy, m_done, m_we_n, m_w2, m_fin, m_par;
  logic [17:0] m_addr, m_ptr;
  logic [15:0] m_data, m_g1b1;
  logic [7:0]  m_b0;
  int          m_cnt;

  always @(posedge clk or posedge rst) begin
    logic was_idle, tx;
    if (rst) begin
      m_ready = 0; m_busy = 0; m_done = 0; m_we_n = 1; m_addr = 0; m_data = 0;
      m_w2 = 0; m_fin = 0; m_par = 0; m_ptr = 0; m_cnt = 0; m_b0 = 0; m_g1b1 = 0;
    end else begin
      was_idle = !m_busy && !m_done;
      tx = valid && m_ready;
      m_we_n = 1;
      m_done = 0;
      if (m_fin) begin
        m_fin = 0; m_done = 1; m_busy = 0;
      end else if (m_w2) begin
        m_we_n = 0; m_addr = m_ptr; m_data = m_g1b1; m_ptr = m_ptr + 1; m_w2 = 0;
        if (m_cnt == NP) m_fin = 1; else m_ready = 1;
      end else if (tx) begin
        m_cnt++; m_we_n = 0; m_addr = m_ptr; m_ptr = m_ptr + 1;
        if (!m_par) begin
          m_data = {pr, pg}; m_b0 = pb;
        end else begin
          m_data = {m_b0, pr}; m_g1b1 = {pg, pb}; m_w2 = 1; m_ready = 0;
        end
        m_par = !m_par;
      end
      if (was_idle && start) begin
        m_ptr = base; m_cnt = 0; m_par = 0; m_busy = 1; m_ready = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("ready", ready, m_ready);
    chk("we_n", we_n, m_we_n);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    if (!m_we_n) begin
      chk("addr", addr, m_addr);
      chk("wdata", wdata, m_data);
    end
  end

  // SRAM image and event counters built from the DUT's write port.
  logic [15:0] mem [0:(1<<18)-1];
  int nwrites = 0, ndone = 0;
  int fr_nw0, fr_nd0;

  always @(posedge clk) begin
    if (!we_n) begin
      mem[addr] = wdata;
      nwrites++;
    end
    if (done) ndone++;
  end

  logic [23:0] src [NP];

  // Drives one frame; returns at the negedge on which Done is high.
  task automatic run_frame(input logic [17:0] b, input int gap, input bit rand_gap, input bit poke);
    int tmo;
    start = 1; base = b;
    @(negedge clk);
    start = 0; base = 18'h15555;
    fr_nw0 = nwrites; fr_nd0 = ndone;
    for (int i = 0; i < NP; i++) begin
      int g;
      g = rand_gap ? $urandom_range(0, 2) : gap;
      if (i > 0) repeat (g) begin valid = 0; @(negedge clk); end
      tmo = 0;
      while (!ready && tmo < 20) begin valid = 0; @(negedge clk); tmo++; end
      if (tmo >= 20) timeout("ready_wait");
      valid = 1; {pr, pg, pb} = src[i];
      if (poke && i == 1) begin start = 1; base = 18'h2AAAA; end
      @(negedge clk);
      start = 0;
    end
    valid = 0;
    tmo = 0;
    while (!done && tmo < 20) begin @(negedge clk); tmo++; end
    if (tmo >= 20) timeout("done_wait");
  endtask

  // Frame totals plus a display-side readback of every pixel.
  task automatic check_frame(input logic [17:0] b);
    logic [17:0] w;
    logic [15:0] w0, w1, w2;
    repeat (3) @(negedge clk);
    chk("frame_words", nwrites - fr_nw0, 3 * NP / 2);
    chk("frame_done_pulses", ndone - fr_nd0, 1);
    for (int k = 0; k < NP; k++) begin
      w  = b + 18'(3 * (k / 2));
      w0 = mem[w]; w1 = mem[w + 18'd1]; w2 = mem[w + 18'd2];
      if (k % 2 == 0) chk("readback_even", {w0[15:8], w0[7:0], w1[15:8]}, src[k]);
      else            chk("readback_odd",  {w1[7:0], w2[15:8], w2[7:0]}, src[k]);
    end
  endtask

  initial begin
    rst = 1; start = 0; base = 0; valid = 0; pr = 0; pg = 0; pb = 0;
    repeat (2) @(negedge clk);
    chk("reset_we_n", we_n, 1);
    chk("reset_addr", addr, 0);
    chk("reset_wdata", wdata, 0);
    chk("reset_ready", ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 0;
    @(negedge clk);

    // Back-to-back pixels from base 0.
    src[0] = 24'h112233; src[1] = 24'h445566; src[2] = 24'h778899; src[3] = 24'hAABBCC;
    run_frame(18'h0, 0, 0, 0);
    check_frame(18'h0);
    chk("t2_w0", mem[0], 16'h1122);
    chk("t2_w1", mem[1], 16'h3344);
    chk("t2_w2", mem[2], 16'h5566);
    chk("t2_w5", mem[5], 16'hBBCC);

    // Same pixels with a 4-cycle valid gap between them.
    for (int a = 0; a < 6; a++) mem[a] = '0;
    run_frame(18'h0, 4, 0, 0);
    check_frame(18'h0);
    chk("t3_w1", mem[1], 16'h3344);
    chk("t3_w4", mem[4], 16'h99AA);

    // Address wrap across 2^18.
    src[0] = 24'h010203; src[1] = 24'h040506; src[2] = 24'h070809; src[3] = 24'h0A0B0C;
    run_frame(18'h3FFFE, 0, 0, 0);
    check_frame(18'h3FFFE);
    chk("t4_3fffe", mem[18'h3FFFE], 16'h0102);
    chk("t4_3ffff", mem[18'h3FFFF], 16'h0304);
    chk("t4_0", mem[0], 16'h0506);
    chk("t4_3", mem[3], 16'h0B0C);
    chk("t4_ready_after", ready, 0);

    // Start during a frame and in the Done cycle are both ignored.
    mem[18'h2000] = '0; mem[18'h2AAAA] = '0;
    run_frame(18'h1000, 1, 0, 1);
    start = 1; base = 18'h2000;
    @(negedge clk);
    start = 0;
    chk("t5_busy_after_done_start", busy, 0);
    check_frame(18'h1000);
    chk("t5_poke_addr_untouched", mem[18'h2AAAA], 0);
    src[0] = 24'hDEADBE; src[1] = 24'hEF0123; src[2] = 24'h456789; src[3] = 24'hABCDEF;
    run_frame(18'h2100, 0, 0, 0);
    check_frame(18'h2100);
    chk("t5_done_start_untouched", mem[18'h2000], 0);
    chk("t5_new_base_w0", mem[18'h2100], 16'hDEAD);

    // Reset mid-frame.
    start = 1; base = 18'h40;
    @(negedge clk);
    start = 0; valid = 1; {pr, pg, pb} = 24'h123456;
    @(negedge clk);
    valid = 0;
    #2 rst = 1;
    #1;
    chk("t1_rst_we_n", we_n, 1);
    chk("t1_rst_ready", ready, 0);
    chk("t1_rst_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    src[0] = 24'h600D01; src[1] = 24'h600D02; src[2] = 24'h600D03; src[3] = 24'h600D04;
    run_frame(18'h40, 0, 0, 0);
    check_frame(18'h40);
    chk("t1_restart_w0", mem[18'h40], 16'h600D);

    // Several frames of random pixels, random gaps and random bases.
    for (int f = 0; f < 6; f++) begin
      logic [17:0] rb;
      rb = 18'($urandom);
      for (int k = 0; k < NP; k++) src[k] = 24'($urandom);
      run_frame(rb, 0, 1, 0);
      check_frame(rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
